// File: rtl/midi_pkg.sv
// Shared MIDI message types and helpers for the pedal controller slice.
package midi_pkg;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [1:0] len;
  } midi_msg_t;

  localparam logic [7:0] CC_MSG = 8'hB0;
  localparam logic [7:0] PC_MSG = 8'hC0;

  function automatic midi_msg_t default_cc(input logic [3:0] chan,
                                           input logic [6:0] cc,
                                           input logic [7:0] val);
    midi_msg_t m;
    m.status = CC_MSG | {4'h0, chan};
    m.data1  = {1'b0, cc};
    m.data2  = val;
    m.len    = 2'd3;
    return m;
  endfunction

endpackage

// File: rtl/midi_pedal_ctrl_if.sv
// Valid/ready message request bus from the pedal controller to the MIDI-out serializer.
interface midi_pedal_ctrl_if;

  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_status;
  logic [7:0] tx_data1;
  logic [7:0] tx_data2;
  logic [1:0] tx_len;

  modport master (output tx_valid, tx_status, tx_data1, tx_data2, tx_len,
                  input  tx_ready);
  modport slave  (input  tx_valid, tx_status, tx_data1, tx_data2, tx_len,
                  output tx_ready);

endinterface

// File: rtl/midi_prio_pick.sv
// Lowest-set-bit picker: one-hot of the winning request plus its binary index.
module midi_prio_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path infers a latch
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/midi_pedal_ctrl.sv
// N-button MIDI footswitch controller with MIDI-learn slots and a valid/ready transmit request.
// Optional build macro MIDI_TOGGLE_EN: CC messages alternate data2 between stored value and 0.
module midi_pedal_ctrl
  import midi_pkg::*;
#(
  parameter int NUM_BTNS      = 4,
  parameter int MIDI_CHANNEL  = 0,
  parameter int FIRST_CC      = 46,
  parameter int CC_VALUE      = 127,
  parameter int LEARN_TIMEOUT = 100_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_rise,
  input  logic                clr_all,
  input  logic                rx_valid,
  input  logic [7:0]          rx_status,
  input  logic [7:0]          rx_data1,
  input  logic [7:0]          rx_data2,
  input  logic [1:0]          rx_len,
  midi_pedal_ctrl_if.master   tx,
  output logic                learn_armed,
  output logic [NUM_BTNS-1:0] slot_valid
);

  localparam int BW = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;
  localparam int TW = (LEARN_TIMEOUT > 1) ? $clog2(LEARN_TIMEOUT) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [0:0]          state;
  logic [TW-1:0]       to_cnt;
  midi_msg_t           learn_buf;
  midi_msg_t           slots [NUM_BTNS];
  logic [NUM_BTNS-1:0] pending;
  logic                tx_valid_q;
  midi_msg_t           tx_msg;
  midi_msg_t           disp_msg;

  logic [NUM_BTNS-1:0] btn_oh,  pend_oh;
  logic [BW-1:0]       btn_idx, pend_idx;
  logic                btn_any, pend_any;

  midi_prio_pick #(.N(NUM_BTNS)) u_learn_pick (
    .req(btn_rise), .onehot(btn_oh), .idx(btn_idx), .any(btn_any)
  );

  midi_prio_pick #(.N(NUM_BTNS)) u_disp_pick (
    .req(pending), .onehot(pend_oh), .idx(pend_idx), .any(pend_any)
  );

  logic armed, rx_take, learn_store, timeout, dispatch, xfer;

  assign armed       = (state == ST_ARMED);
  assign rx_take     = rx_valid && (rx_len != 2'd0);
  assign learn_store = armed && btn_any;
  assign timeout     = armed && (to_cnt == TW'(LEARN_TIMEOUT - 1));
  assign dispatch    = !tx_valid_q && pend_any;
  assign xfer        = tx_valid_q && tx.tx_ready;

  // Learn buffer FSM: a fresh message always re-arms, even while already armed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      to_cnt    <= '0;
      learn_buf <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking so every block sees pre-edge values
      if (rx_take) begin
        state     <= ST_ARMED;
        to_cnt    <= '0;
        learn_buf <= '{status: rx_status, data1: rx_data1, data2: rx_data2, len: rx_len};
      end else if (learn_store || timeout) begin
        state <= ST_IDLE;
      end else if (armed) begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

  // NOTE: slot contents carry no reset; slot_valid alone says whether they mean anything
  always_ff @(posedge clk) begin
    if (learn_store) slots[btn_idx] <= learn_buf;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             slot_valid <= '0;
    else if (clr_all)     slot_valid <= '0;
    else if (learn_store) slot_valid <= slot_valid | btn_oh;
  end

`ifdef MIDI_TOGGLE_EN
  logic [NUM_BTNS-1:0] toggle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         toggle <= '0;
    else if (clr_all) toggle <= '0;
    else              toggle <= (toggle ^ (dispatch ? pend_oh : '0))
                                & ~(learn_store ? btn_oh : '0);
  end
`endif

  always_comb begin
    disp_msg = slot_valid[pend_idx]
             ? slots[pend_idx]
             : default_cc(4'(MIDI_CHANNEL), 7'(FIRST_CC + int'(pend_idx)), 8'(CC_VALUE));
`ifdef MIDI_TOGGLE_EN
    if ((disp_msg.status[7:4] == CC_MSG[7:4]) && toggle[pend_idx]) disp_msg.data2 = 8'h00;
`endif
  end

  // Presses only queue while idle; an armed press is consumed by the learn store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= '0;
      tx_valid_q <= 1'b0;
      tx_msg     <= '0;
    end else begin
      pending <= (pending & ~(dispatch ? pend_oh : '0)) | (armed ? '0 : btn_rise);
      if (dispatch) begin
        tx_valid_q <= 1'b1;
        tx_msg     <= disp_msg;
      end else if (xfer) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  assign tx.tx_valid  = tx_valid_q;
  assign tx.tx_status = tx_msg.status;
  assign tx.tx_data1  = tx_msg.data1;
  assign tx.tx_data2  = tx_msg.data2;
  assign tx.tx_len    = tx_msg.len;
  assign learn_armed  = state[0];

endmodule
